rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: AW, 5, register address width.
REQ-002 Parameter: DW, 32, data width.
REQ-003 Parameter: NREG, 32, number of architectural registers; equals 2**AW.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 a_valid  in  1  ALU writeback request.
REQ-007 a_ad  in  AW  ALU destination register.
REQ-008 a_wd  in  DW  ALU write data.
REQ-009 a_ready  out  1  grant to ALU; the transfer occurs when a_valid and a_ready are both high.
REQ-010 b_valid, b_ad, b_wd, b_ready  in/in/in/out  1/AW/DW/1  load-return requester, same semantics as A.
REQ-011 rsv_valid  in  1  reserve a destination for an issued load.
REQ-012 rsv_ad  in  AW  register to reserve.
REQ-013 q1_ad, q2_ad  in  AW  scoreboard query addresses (source operands).
REQ-014 busy1, busy2  out  1  queried register has a pending load write.
REQ-015 we3, ad3, wd3  out  1/AW/DW  registered write port driving the register file.

Function
REQ-016 Arbitration SHALL be combinational, in the same cycle as the request: a_ready = a_valid and (not b_valid or last_grant = B); b_ready = b_valid and (not a_valid or last_grant = A).
REQ-017 last_grant SHALL update to the granted requester on every transfer and SHALL hold when no transfer occurs.
REQ-018 At most one of a_ready and b_ready SHALL be high in any cycle; neither SHALL be high while rst is high.
REQ-019 A transfer in cycle N SHALL drive we3=1, ad3=granted ad and wd3=granted wd in cycle N+1, giving a latency of exactly 1.
REQ-020 A transfer with ad = 0 SHALL be accepted (ready high) but SHALL produce we3=0 in cycle N+1.
REQ-021 When there is no transfer in cycle N, we3 SHALL be 0 in cycle N+1, and ad3/wd3 SHALL hold their previous values.
REQ-022 The scoreboard SHALL be NREG busy bits; bit 0 SHALL be constantly 0.
REQ-023 rsv_valid with rsv_ad != 0 SHALL set busy[rsv_ad] at the clock edge.
REQ-024 A B-transfer in cycle N SHALL clear busy[b_ad] at the end of cycle N+1, the edge at which the register file captures the write, so busy reads 0 from cycle N+2.
REQ-025 A-transfers SHALL NOT modify the scoreboard.
REQ-026 If a set and a clear target the same bit on the same edge, the set SHALL win (a newer load is outstanding).
REQ-027 busy1 = busy[q1_ad] and busy2 = busy[q2_ad], combinational from registered state with no bypass of the same-cycle reserve.
REQ-028 rsv_valid to a register that is already busy SHALL leave the bit set, with no error or count.

Reset
REQ-029 On rst: we3=0, ad3=0, wd3=0, all busy bits 0, last_grant=B (so A wins the first tie).
REQ-030 On rst: a transfer presented in the reset cycle SHALL be discarded, and an in-flight write from the cycle before reset SHALL NOT assert we3 after reset.
REQ-031 Reset SHALL take priority over every set, clear and grant in the same cycle.

Structure
REQ-032 AW, DW, NREG and the requester encoding (REQ_A, REQ_B) SHALL live in the shared processor package.
REQ-033 The scoreboard SHALL be one sub-module, rf_scoreboard (set/clear/query ports); the arbiter and write-port register SHALL be in the top module.
REQ-034 The block SHALL contain no latches; the RTL target is 150-250 lines.

Verification
REQ-035 After reset, a_valid=1, a_ad=5, a_wd=0x0000_00AA -> a_ready=1 the same cycle; next cycle we3=1, ad3=5, wd3=0x0000_00AA.
REQ-036 Both requesters valid for 4 cycles after reset (a_ad=1, b_ad=2) -> grants A,B,A,B; we3 is high for 4 consecutive cycles, one cycle delayed.
REQ-037 Write with a_ad=0, a_wd=0xFFFF_FFFF -> a_ready=1; next cycle we3=0.
REQ-038 rsv_valid with rsv_ad=7, then q1_ad=7 -> busy1=1; B-transfer b_ad=7 in cycle N -> busy1=1 in N+1, busy1=0 in N+2.
REQ-039 B-transfer b_ad=9 in cycle N and rsv_valid with rsv_ad=9 in cycle N+1 -> busy[9] stays 1 from N+2 onward.
REQ-040 Reserve x3, then assert rst while b_valid=1 -> b_ready=0, busy all 0, and we3=0 in the cycle after reset.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter_pkg
// Shared processor definitions for the register-file writeback path:
//   AW   - register address width
//   DW   - register data width
//   NREG - number of architectural registers (2**AW)
//   req_e - writeback requester encoding (REQ_A = ALU, REQ_B = load return)
// -----------------------------------------------------------------------------
package rf_wb_arbiter_pkg;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 2 ** AW;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// One busy bit per architectural register, marking registers that still wait
// for a load result. Register 0 is hard-wired to never be busy.
// Ports:
//   clk, rst            - clock, synchronous active-high reset (clears all bits)
//   i_set_vld/i_set_ad  - mark a register busy at the next edge
//   i_clr_vld/i_clr_ad  - mark a register free at the next edge
//   i_q1_ad/i_q2_ad     - query addresses
//   o_busy1/o_busy2     - busy state of the queried registers (registered state)
// -----------------------------------------------------------------------------
module rf_scoreboard #(
  parameter int AW   = rf_wb_arbiter_pkg::AW,
  parameter int NREG = rf_wb_arbiter_pkg::NREG
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_set_vld,
  input  logic [AW-1:0] i_set_ad,
  input  logic          i_clr_vld,
  input  logic [AW-1:0] i_clr_ad,
  input  logic [AW-1:0] i_q1_ad,
  input  logic [AW-1:0] i_q2_ad,
  output logic          o_busy1,
  output logic          o_busy2
);
  import rf_wb_arbiter_pkg::*;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_busy_nxt;

  // Clear first, then set: a reserve landing on the same edge as the
  // writeback of an older load belongs to a newer load, so it must survive.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_vld) w_set_mask[i_set_ad] = 1'b1;
    if (i_clr_vld) w_clr_mask[i_clr_ad] = 1'b1;
    w_busy_nxt    = (r_busy & ~w_clr_mask) | w_set_mask;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  // Query reads registered state only; a same-cycle reserve is not bypassed.
  assign o_busy1 = r_busy[i_q1_ad];
  assign o_busy2 = r_busy[i_q2_ad];

endmodule

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
// Arbitrates the single register-file write port between the ALU (A) and the
// load-return path (B), registers the winning write, and tracks outstanding
// load destinations in a scoreboard.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   a_valid/a_ad/a_wd, a_ready    - ALU writeback request and grant
//   b_valid/b_ad/b_wd, b_ready    - load-return writeback request and grant
//   rsv_valid/rsv_ad              - reserve a load destination register
//   q1_ad/q2_ad, busy1/busy2      - scoreboard queries for source operands
//   we3/ad3/wd3                   - registered register-file write port
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int AW   = rf_wb_arbiter_pkg::AW,
  parameter int DW   = rf_wb_arbiter_pkg::DW,
  parameter int NREG = rf_wb_arbiter_pkg::NREG
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [AW-1:0] a_ad,
  input  logic [DW-1:0] a_wd,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_ad,
  input  logic [DW-1:0] b_wd,
  output logic          b_ready,
  input  logic          rsv_valid,
  input  logic [AW-1:0] rsv_ad,
  input  logic [AW-1:0] q1_ad,
  input  logic [AW-1:0] q2_ad,
  output logic          busy1,
  output logic          busy2,
  output logic          we3,
  output logic [AW-1:0] ad3,
  output logic [DW-1:0] wd3
);
  import rf_wb_arbiter_pkg::*;

  req_e          r_last_grant;
  logic          r_we3;
  logic [AW-1:0] r_ad3;
  logic [DW-1:0] r_wd3;
  logic          r_clr_pend;

  logic          w_a_ready;
  logic          w_b_ready;
  logic          w_xfer;
  logic [AW-1:0] w_g_ad;
  logic [DW-1:0] w_g_wd;

  // Round-robin on ties: the requester not granted last time wins.
  always_comb begin
    w_a_ready = a_valid & ~rst & (~b_valid | (r_last_grant == REQ_B));
    w_b_ready = b_valid & ~rst & (~a_valid | (r_last_grant == REQ_A));
    w_xfer    = w_a_ready | w_b_ready;
    w_g_ad    = w_b_ready ? b_ad : a_ad;
    w_g_wd    = w_b_ready ? b_wd : a_wd;
  end

  // Write-port stage: one cycle after the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= REQ_B;
      r_we3        <= 1'b0;
      r_ad3        <= '0;
      r_wd3        <= '0;
      r_clr_pend   <= 1'b0;
    end else begin
      if (w_a_ready)      r_last_grant <= REQ_A;
      else if (w_b_ready) r_last_grant <= REQ_B;
      // Writes to register 0 are accepted but never reach the register file.
      r_we3      <= w_xfer && (w_g_ad != '0);
      // The load's busy bit is released on the edge the register file
      // captures the write, i.e. while that write sits on ad3.
      r_clr_pend <= w_b_ready && (b_ad != '0);
      if (w_xfer) begin
        r_ad3 <= w_g_ad;
        r_wd3 <= w_g_wd;
      end
    end
  end

  rf_scoreboard #(
    .AW   (AW),
    .NREG (NREG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .i_set_vld (rsv_valid),
    .i_set_ad  (rsv_ad),
    .i_clr_vld (r_clr_pend),
    .i_clr_ad  (r_ad3),
    .i_q1_ad   (q1_ad),
    .i_q2_ad   (q2_ad),
    .o_busy1   (busy1),
    .o_busy2   (busy2)
  );

  assign a_ready = w_a_ready;
  assign b_ready = w_b_ready;
  assign we3     = r_we3;
  assign ad3     = r_ad3;
  assign wd3     = r_wd3;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, rsv_valid = 1'b0;
  logic [4:0]  a_ad = '0, b_ad = '0, rsv_ad = '0, q1_ad = '0, q2_ad = '0;
  logic [31:0] a_wd = '0, b_wd = '0;
  logic        a_ready, b_ready, busy1, busy2, we3;
  logic [4:0]  ad3;
  logic [31:0] wd3;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ad(a_ad), .a_wd(a_wd), .a_ready(a_ready),
    .b_valid(b_valid), .b_ad(b_ad), .b_wd(b_wd), .b_ready(b_ready),
    .rsv_valid(rsv_valid), .rsv_ad(rsv_ad),
    .q1_ad(q1_ad), .q2_ad(q2_ad), .busy1(busy1), .busy2(busy2),
    .we3(we3), .ad3(ad3), .wd3(wd3)
  );

  // Expected outputs for one cycle.
  typedef struct {
    bit          chk_state;
    bit          chk_data;
    bit          ar, br, b1, b2, we;
    logic [4:0]  ad;
    logic [31:0] wd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state (what the outputs should show this cycle).
  bit          m_lg_b  = 1'b1;          // last grant was B
  bit          m_busy[32];
  bit          m_we    = 1'b0;
  logic [4:0]  m_ad    = '0;
  logic [31:0] m_wd    = '0;
  bit          m_sknown = 1'b0;         // DUT state defined (after first reset)
  bit          m_dknown = 1'b0;         // ad3/wd3 value defined by the spec
  bit          m_clr   = 1'b0;
  logic [4:0]  m_clr_ad = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, expv);
    end
  endtask

  // Monitor: pops the expectation for the current cycle and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a_ready", {31'b0, a_ready}, {31'b0, e.ar});
        chk("b_ready", {31'b0, b_ready}, {31'b0, e.br});
        if (e.chk_state) begin
          chk("busy1", {31'b0, busy1}, {31'b0, e.b1});
          chk("busy2", {31'b0, busy2}, {31'b0, e.b2});
          chk("we3",   {31'b0, we3},   {31'b0, e.we});
        end
        if (e.chk_data) begin
          chk("ad3", {27'b0, ad3}, {27'b0, e.ad});
          chk("wd3", wd3, e.wd);
        end
      end
    end
  end

  // One cycle of stimulus: drive inputs, push expectation, advance model.
  task automatic step(input bit r,
                      input bit av, input logic [4:0] aad, input logic [31:0] awd,
                      input bit bv, input logic [4:0] bad_i, input logic [31:0] bwd,
                      input bit rv, input logic [4:0] rad,
                      input logic [4:0] q1, input logic [4:0] q2);
    exp_t e;
    bit   ga, gb;
    @(posedge clk);
    #1;
    rst = r; a_valid = av; a_ad = aad; a_wd = awd;
    b_valid = bv; b_ad = bad_i; b_wd = bwd;
    rsv_valid = rv; rsv_ad = rad; q1_ad = q1; q2_ad = q2;

    ga = 1'b0; gb = 1'b0;
    if (!r) begin
      if (av && bv) begin
        if (m_lg_b) ga = 1'b1; else gb = 1'b1;
      end else begin
        ga = av; gb = bv;
      end
    end
    e.chk_state = m_sknown;
    e.chk_data  = m_sknown && m_dknown;
    e.ar = ga; e.br = gb;
    e.b1 = m_busy[q1]; e.b2 = m_busy[q2];
    e.we = m_we; e.ad = m_ad; e.wd = m_wd;
    exp_q.push_back(e);

    // Effect of the coming clock edge.
    if (r) begin
      m_lg_b = 1'b1;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_we = 1'b0; m_ad = '0; m_wd = '0;
      m_clr = 1'b0;
      m_sknown = 1'b1; m_dknown = 1'b1;
    end else begin
      if (m_clr) m_busy[m_clr_ad] = 1'b0;
      if (rv && rad != 0) m_busy[rad] = 1'b1;
      m_clr = gb && (bad_i != 0);
      m_clr_ad = bad_i;
      if (ga || gb) begin
        m_lg_b = gb;
        m_ad = ga ? aad : bad_i;
        m_wd = ga ? awd : bwd;
        m_we = (m_ad != 0);
        m_dknown = (m_ad != 0);
      end else begin
        m_we = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n, input logic [4:0] q1, input logic [4:0] q2);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, q1, q2);
  endtask

  initial begin
    foreach (m_busy[i]) m_busy[i] = 1'b0;

    // Reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single ALU write
    step(0, 1, 5, 32'h0000_00AA, 0, 0, 0, 0, 0, 5, 0);
    idle(1, 0, 0);

    // Alternating grants from reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 32'h1100 + i, 1, 2, 32'h2200 + i, 0, 0, 1, 2);
    idle(2, 0, 0);

    // Write to register 0
    step(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 0, 0);

    // Reserve then release register 7
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    idle(1, 7, 0);
    step(0, 0, 0, 0, 1, 7, 32'h7777_0007, 0, 0, 7, 0);
    idle(3, 7, 0);

    // Clear and new reserve on the same edge: set wins
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    step(0, 0, 0, 0, 1, 9, 32'h9999_0009, 0, 0, 9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    idle(3, 9, 0);

    // Reset while loads are outstanding and B is requesting
    step(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 4);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4, 3, 4);
    step(0, 1, 6, 32'h6666, 0, 0, 0, 1, 5, 3, 4);
    step(1, 0, 0, 0, 1, 3, 32'h3333, 0, 0, 3, 4);
    idle(1, 3, 4);
    idle(1, 5, 0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 63) == 0),
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(2, 0, 0);

    @(posedge clk);
    #6;
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
